// File: rtl/soc_system_reset_pulse_pio.sv
// Avalon-MM output PIO for per-bit reset/control lines: level register with
// atomic SET/CLEAR plus a self-timed pulse mask that drops after PULSE_LEN cycles.
module soc_system_reset_pulse_pio #(
  parameter int unsigned DATA_WIDTH        = 32,
  parameter logic [31:0] RESET_VALUE       = '0,
  parameter int unsigned CNT_WIDTH         = 16,
  parameter int unsigned DEFAULT_PULSE_LEN = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [2:0]            address,
  input  logic                  chipselect,
  input  logic                  write_n,
  input  logic [31:0]           writedata,
  output logic [31:0]           readdata,
  output logic [DATA_WIDTH-1:0] out_port
);

  localparam logic [2:0] ADDR_LEVEL     = 3'd0;
  localparam logic [2:0] ADDR_SET       = 3'd1;
  localparam logic [2:0] ADDR_CLEAR     = 3'd2;
  localparam logic [2:0] ADDR_PULSE     = 3'd3;
  localparam logic [2:0] ADDR_PULSE_LEN = 3'd4;
  localparam logic [2:0] ADDR_STATUS    = 3'd5;

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_ACTIVE = 1'b1;

  logic [DATA_WIDTH-1:0] level_q, level_d;
  logic [DATA_WIDTH-1:0] mask_q,  mask_d;
  logic [CNT_WIDTH-1:0]  cnt_q,   cnt_d;
  logic [CNT_WIDTH-1:0]  plen_q,  plen_d;
  logic [0:0]            state_q, state_d;

  logic                  wr_en;
  logic                  reload;
  logic                  busy;
  logic [DATA_WIDTH-1:0] wdata_dw;
  logic [CNT_WIDTH-1:0]  load_val;

  always_comb begin
    wr_en    = chipselect & ~write_n;
    wdata_dw = writedata[DATA_WIDTH-1:0];
    reload   = wr_en && (address == ADDR_PULSE) && (wdata_dw != '0);
    // A programmed length of 0 still yields a one-cycle pulse
    load_val = (plen_q == '0) ? CNT_WIDTH'(1) : plen_q;
    busy     = (mask_q != '0);
  end

  // Register writes and pulse FSM; reload wins over the countdown
  always_comb begin
    level_d = level_q;
    mask_d  = mask_q;
    cnt_d   = cnt_q;
    plen_d  = plen_q;
    state_d = state_q;

    if (wr_en) begin
      case (address)
        ADDR_LEVEL:     level_d = wdata_dw;
        ADDR_SET:       level_d = level_q | wdata_dw;
        ADDR_CLEAR:     level_d = level_q & ~wdata_dw;
        ADDR_PULSE_LEN: plen_d  = writedata[CNT_WIDTH-1:0];
        default:        ;
      endcase
    end

    case (state_q)
      ST_IDLE: begin
        if (reload) begin
          mask_d  = mask_q | wdata_dw;
          cnt_d   = load_val;
          state_d = ST_ACTIVE;
        end
      end
      ST_ACTIVE: begin
        if (reload) begin
          mask_d = mask_q | wdata_dw;
          cnt_d  = load_val;
        end else if (cnt_q == CNT_WIDTH'(1)) begin
          mask_d  = '0;
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - CNT_WIDTH'(1);
        end
      end
      default: begin
        mask_d  = '0;
        cnt_d   = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      level_q <= DATA_WIDTH'(RESET_VALUE);
      mask_q  <= '0;
      cnt_q   <= '0;
      plen_q  <= CNT_WIDTH'(DEFAULT_PULSE_LEN);
      state_q <= ST_IDLE;
    end else begin
      level_q <= level_d;
      mask_q  <= mask_d;
      cnt_q   <= cnt_d;
      plen_q  <= plen_d;
      state_q <= state_d;
    end
  end

  // Zero-wait-state read mux
  always_comb begin
    readdata = '0;
    case (address)
      ADDR_LEVEL, ADDR_SET, ADDR_CLEAR: readdata = 32'(level_q);
      ADDR_PULSE:                       readdata = 32'(mask_q);
      ADDR_PULSE_LEN:                   readdata = 32'(plen_q);
      ADDR_STATUS:                      readdata = 32'({cnt_q, busy});
      default:                          readdata = '0;
    endcase
  end

  assign out_port = level_q | mask_q;

endmodule

// File: tb/tb_soc_system_reset_pulse_pio.sv
// Directed bench for soc_system_reset_pulse_pio: vector table for register and
// pulse behaviour, plus sequences for reset, reload and read-during-write.
module tb_soc_system_reset_pulse_pio;

  localparam int unsigned DW = 12;

  logic          clk;
  logic          reset;
  logic [2:0]    address;
  logic          chipselect;
  logic          write_n;
  logic [31:0]   writedata;
  logic [31:0]   readdata;
  logic [DW-1:0] out_port;

  int n_checks;
  int n_errors;

  soc_system_reset_pulse_pio #(
    .DATA_WIDTH(DW),
    .RESET_VALUE(32'h5),
    .CNT_WIDTH(8),
    .DEFAULT_PULSE_LEN(16)
  ) dut (
    .clk(clk),
    .reset(reset),
    .address(address),
    .chipselect(chipselect),
    .write_n(write_n),
    .writedata(writedata),
    .readdata(readdata),
    .out_port(out_port)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic          wr;
    logic [2:0]    addr;
    logic [31:0]   data;
    logic [2:0]    raddr;
    logic [DW-1:0] exp_out;
    logic [31:0]   exp_rd;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic wr, logic [2:0] addr, logic [31:0] data,
                              logic [2:0] raddr, logic [DW-1:0] exp_out,
                              logic [31:0] exp_rd);
    vec_t v;
    v.wr = wr; v.addr = addr; v.data = data; v.raddr = raddr;
    v.exp_out = exp_out; v.exp_rd = exp_rd;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive_wr(input logic [2:0] a, input logic [31:0] d);
    address = a; chipselect = 1'b1; write_n = 1'b0; writedata = d;
  endtask

  task automatic drive_idle(input logic [2:0] a);
    address = a; chipselect = 1'b0; write_n = 1'b1; writedata = '0;
  endtask

  // One clock edge with optional write, then release the bus and point reads at raddr
  task automatic cycle(input logic wr, input logic [2:0] a, input logic [31:0] d,
                       input logic [2:0] raddr);
    if (wr) drive_wr(a, d);
    else    drive_idle(a);
    @(posedge clk);
    #1;
    drive_idle(raddr);
    #1;
  endtask

  int cnt0, cnt1, last0, last1;

  initial begin
    n_checks = 0;
    n_errors = 0;
    reset    = 1'b1;
    drive_idle(3'd0);

    // Vector table
    vecs.push_back(mk(1, 3'd0, 32'h0A0,      3'd0, 12'h0A0, 32'h0A0));
    vecs.push_back(mk(1, 3'd0, 32'h0F0,      3'd0, 12'h0F0, 32'h0F0));
    vecs.push_back(mk(1, 3'd1, 32'h003,      3'd1, 12'h0F3, 32'h0F3));
    vecs.push_back(mk(1, 3'd2, 32'h030,      3'd2, 12'h0C3, 32'h0C3));
    vecs.push_back(mk(1, 3'd6, 32'hFFF,      3'd6, 12'h0C3, 32'h0));
    vecs.push_back(mk(1, 3'd7, 32'h001,      3'd0, 12'h0C3, 32'h0C3));
    vecs.push_back(mk(1, 3'd0, 32'hFFFFF000, 3'd0, 12'h000, 32'h0));
    vecs.push_back(mk(1, 3'd0, 32'hFFFFFFFF, 3'd0, 12'hFFF, 32'hFFF));
    vecs.push_back(mk(1, 3'd0, 32'h0,        3'd0, 12'h000, 32'h0));
    // 4-cycle pulse on bit 8; STATUS = {cnt, busy}
    vecs.push_back(mk(1, 3'd4, 32'h4,        3'd4, 12'h000, 32'h4));
    vecs.push_back(mk(1, 3'd3, 32'h100,      3'd5, 12'h100, 32'h9));
    vecs.push_back(mk(0, 3'd0, 32'h0,        3'd5, 12'h100, 32'h7));
    vecs.push_back(mk(0, 3'd0, 32'h0,        3'd5, 12'h100, 32'h5));
    vecs.push_back(mk(0, 3'd0, 32'h0,        3'd3, 12'h100, 32'h100));
    vecs.push_back(mk(0, 3'd0, 32'h0,        3'd5, 12'h000, 32'h0));
    // length 0 behaves as 1; zero-data pulse is ignored
    vecs.push_back(mk(1, 3'd4, 32'h0,        3'd4, 12'h000, 32'h0));
    vecs.push_back(mk(1, 3'd3, 32'h1,        3'd3, 12'h001, 32'h1));
    vecs.push_back(mk(0, 3'd0, 32'h0,        3'd5, 12'h000, 32'h0));
    vecs.push_back(mk(1, 3'd3, 32'h0,        3'd5, 12'h000, 32'h0));
    vecs.push_back(mk(0, 3'd0, 32'h0,        3'd5, 12'h000, 32'h0));
    // level bit 0 survives the end of a pulse on the same bit
    vecs.push_back(mk(1, 3'd0, 32'h1,        3'd0, 12'h001, 32'h1));
    vecs.push_back(mk(1, 3'd4, 32'h2,        3'd4, 12'h001, 32'h2));
    vecs.push_back(mk(1, 3'd3, 32'h3,        3'd5, 12'h003, 32'h5));
    vecs.push_back(mk(0, 3'd0, 32'h0,        3'd5, 12'h003, 32'h3));
    vecs.push_back(mk(0, 3'd0, 32'h0,        3'd5, 12'h001, 32'h0));
    vecs.push_back(mk(0, 3'd0, 32'h0,        3'd0, 12'h001, 32'h1));
    vecs.push_back(mk(1, 3'd0, 32'h0,        3'd0, 12'h000, 32'h0));

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("reset_out_port", 32'(out_port), 32'h5);
    reset = 1'b0;
    drive_idle(3'd5); #1;
    check("reset_status", readdata, 32'h0);
    drive_idle(3'd4); #1;
    check("reset_pulse_len", readdata, 32'd16);
    drive_idle(3'd0); #1;
    check("reset_level", readdata, 32'h5);

    // Read in the write cycle returns the pre-write value
    drive_wr(3'd0, 32'h3C); #1;
    check("rd_during_wr_old", readdata, 32'h5);
    @(posedge clk); #1;
    drive_idle(3'd0); #1;
    check("rd_after_wr_out", 32'(out_port), 32'h3C);
    check("rd_after_wr_rd", readdata, 32'h3C);

    foreach (vecs[i]) begin
      cycle(vecs[i].wr, vecs[i].addr, vecs[i].data, vecs[i].raddr);
      check($sformatf("vec%0d_out", i), 32'(out_port), 32'(vecs[i].exp_out));
      check($sformatf("vec%0d_rd", i), readdata, vecs[i].exp_rd);
    end

    // Reload mid-pulse: both bits drop on the same edge; PULSE_LEN change mid-pulse has no effect
    cycle(1, 3'd4, 32'd10, 3'd0);
    cycle(1, 3'd3, 32'h1, 3'd0);
    cnt0 = 0; cnt1 = 0; last0 = -1; last1 = -1;
    if (out_port[0]) begin cnt0++; last0 = 0; end
    if (out_port[1]) begin cnt1++; last1 = 0; end
    for (int i = 1; i < 20; i++) begin
      if (i == 3)      cycle(1, 3'd3, 32'h2, 3'd0);
      else if (i == 5) cycle(1, 3'd4, 32'h2, 3'd0);
      else             cycle(0, 3'd0, 32'h0, 3'd0);
      if (out_port[0]) begin cnt0++; last0 = i; end
      if (out_port[1]) begin cnt1++; last1 = i; end
    end
    check("reload_bit0_cycles", 32'(cnt0), 32'd13);
    check("reload_bit1_cycles", 32'(cnt1), 32'd10);
    check("reload_bit0_last", 32'(last0), 32'd12);
    check("reload_bit1_last", 32'(last1), 32'd12);
    drive_idle(3'd4); #1;
    check("reload_new_len", readdata, 32'd2);

    // Reset two cycles into an 8-cycle pulse, with a competing write
    cycle(1, 3'd4, 32'd8, 3'd0);
    cycle(1, 3'd3, 32'h400, 3'd5);
    check("rstpulse_start_out", 32'(out_port), 32'h400);
    check("rstpulse_start_status", readdata, 32'h11);
    cycle(0, 3'd0, 32'h0, 3'd0);
    reset = 1'b1;
    drive_wr(3'd0, 32'hFFF);
    @(posedge clk); #1;
    reset = 1'b0;
    drive_idle(3'd5); #1;
    check("rstpulse_out", 32'(out_port), 32'h5);
    check("rstpulse_status", readdata, 32'h0);
    drive_idle(3'd4); #1;
    check("rstpulse_len", readdata, 32'd16);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/soc_system_reset_pulse_pio.md
# soc_system_reset_pulse_pio

Parametrised Avalon-MM output PIO that drives per-bit reset and control lines into accelerator cores, e.g. the AES and TDC blocks. It is the successor to the plain write-only output PIO. It adds a configurable width and reset value, atomic SET/CLEAR registers, and a self-timed pulse mode: selected bits assert for a programmable number of clock cycles and then drop without further software action. It sits on the HPS lightweight bridge, one instance per controlled subsystem.

## Interface
- DATA_WIDTH, 32: number of output bits, 1..32.
- RESET_VALUE, 0: value of the level register after reset, DATA_WIDTH bits.
- CNT_WIDTH, 16: width of the pulse length register and counter, 1..32.
- DEFAULT_PULSE_LEN, 16: PULSE_LEN value after reset.

- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- address  in  3  word address of the register.
- chipselect  in  1  slave select.
- write_n  in  1  active-low write strobe; a write happens when chipselect=1 and write_n=0.
- writedata  in  32  write data; bits at or above DATA_WIDTH are ignored.
- readdata  out  32  read data, combinational from address; unused bits are 0.
- out_port  out  DATA_WIDTH  driven lines = level_reg | pulse_mask.

## Operation
- Register map. Each write cycle updates at most one register.
  - 0 LEVEL (RW): level_reg <= writedata.
  - 1 SET (W): level_reg <= level_reg | writedata. Reads return level_reg.
  - 2 CLEAR (W): level_reg <= level_reg & ~writedata. Reads return level_reg.
  - 3 PULSE (W): pulse_mask <= pulse_mask | writedata, and cnt <= max(PULSE_LEN,1). Reads return pulse_mask.
  - 4 PULSE_LEN (RW): length in cycles. Value 0 is treated as 1 when loaded into cnt.
  - 5 STATUS (R): bit0 = busy (pulse_mask != 0). Bits [CNT_WIDTH:1] = cnt, truncated at bit 31.
  - 6, 7: writes are ignored; reads return 0.
- Pulse state machine:
  - IDLE: pulse_mask = 0 and cnt = 0.
  - IDLE → ACTIVE on a PULSE write with nonzero writedata[DATA_WIDTH-1:0]. A PULSE write with zero data has no effect.
  - ACTIVE: cnt decrements each cycle.
  - ACTIVE → IDLE on the edge where cnt == 1. On that edge pulse_mask <= 0 and cnt <= 0.
  - A PULSE write during ACTIVE ORs the new bits into the mask and reloads cnt. All mask bits, old and new, stay asserted for the full new length. A reload takes priority over the decrement.
- A PULSE_LEN write during ACTIVE does not alter the running cnt; it applies from the next PULSE write.
- LEVEL, SET and CLEAR never touch pulse_mask. A bit held high by level_reg stays high after its pulse ends.
- Reset values: level_reg = RESET_VALUE, pulse_mask = 0, cnt = 0, PULSE_LEN = DEFAULT_PULSE_LEN, out_port = RESET_VALUE. readdata follows address.

## Timing
- Write latency: a write sampled at edge N is visible on out_port and readdata from edge N onward, so the effect appears in the cycle after the write cycle.
- Read latency 0 with no wait states. A read in the same cycle as a write returns the pre-write value.
- Pulse width: a PULSE write at edge N with PULSE_LEN = L ≥ 1 holds the mask bits high for exactly L cycles, on edges N .. N+L-1. They drop at edge N+L.
- A PULSE reload at edge M restarts timing: the bits drop at edge M+L.
- Reset asserted mid-pulse: at the next edge the pulse is aborted, out_port = RESET_VALUE and busy = 0. Reset has priority over any write in the same cycle.
- With DATA_WIDTH < 32: upper writedata bits are ignored and the upper readdata bits read 0.

## Test plan
- Reset with RESET_VALUE=0x5: out_port=0x5, STATUS=0, PULSE_LEN=16. Write LEVEL=0xA0 → out_port=0xA0 next cycle, and a LEVEL read returns 0xA0.
- LEVEL=0xF0, SET 0x03, then CLEAR 0x30 → out_port 0xF3, then 0xC3. Any write to address 6 → no change, and reading address 6 returns 0.
- PULSE_LEN=4, PULSE 0x100 → bit 8 high for exactly 4 cycles. STATUS reads 0x9, 0x7, 0x5, 0x3 on successive cycles, then 0.
- PULSE_LEN=0, PULSE 0x1 → a 1-cycle pulse. PULSE 0x0 → no pulse and busy stays 0.
- PULSE_LEN=10, PULSE 0x1; after 3 cycles PULSE 0x2 → bit 0 high for 13 cycles total, bit 1 for 10, and both drop on the same edge. A PULSE_LEN=2 write mid-pulse does not shorten the pulse.
- level_reg bit0=1 plus a pulse on bit0 → bit0 stays high after the pulse ends. Reset asserted 2 cycles into an 8-cycle pulse → out_port=RESET_VALUE and STATUS=0 next cycle.
